collatz_sweep: RTL
==================

# collatz_sweep

Host-side sequencer that drives the byte-wide IO/COMPUTE protocol of the Collatz compute core. It runs the core over a contiguous range of seeds and reports the seed with the longest orbit, along with that orbit's length and peak. It sits directly upstream of the core: it owns the core's `ui_in`/`uio_in` pins and consumes `uo_out`/`uio_out[7]`. It replaces manual poking of addresses from the board harness.

## Interface

Parameters:
- `SEED_BITS`, 32: width of seed base and result seed; zero-extended to 64 bits when written to the core.
- `COUNT_BITS`, 16: width of the seed-count input.
- `TIMEOUT`, 1048575: maximum number of WAIT cycles per seed before the run is abandoned.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous assert, active-low; all registers clear.
- `start`, in, 1: one-cycle pulse; accepted only in IDLE.
- `seed_base`, in, SEED_BITS: first seed; sampled on an accepted `start`.
- `seed_count`, in, COUNT_BITS: number of seeds; sampled on an accepted `start`; 0 means done immediately.
- `busy`, out, 1: high from the accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse at the end of a sweep.
- `best_seed`, out, SEED_BITS: seed with the longest orbit.
- `best_len`, out, 16: orbit length of `best_seed`.
- `best_peak`, out, 64: path record of `best_seed`.
- `ovf_count`, out, COUNT_BITS: seeds that overflowed the core.
- `tmo_count`, out, COUNT_BITS: seeds abandoned on timeout.
- `core_data`, out, 8: drives the core's `ui_in`.
- `core_ctrl`, out, 8: drives the core's `uio_in`. Bit 7 is write, bit 6 is go, bit 4 selects path record, bits 3:0 are the address. Bit 5 is always 0.
- `core_rdata`, in, 8: from the core's `uo_out`.
- `core_busy`, in, 1: from the core's `uio_out[7]`.

## Operation

- All outputs reset to 0. `core_ctrl` = 0 outside the WRITE, GO and READ states.
- FSM states:
  - **IDLE**
    - An accepted `start` loads `cur_seed`=`seed_base` and `remaining`=`seed_count`.
    - It clears all result registers and counters.
    - Next state is CHECK.
  - **CHECK**
    - If `remaining`==0, pulse `done` and go to IDLE.
    - If `cur_seed`<3, skip the seed without touching the core and go to NEXT. Seeds below 3 never terminate on the core.
    - Otherwise go to BASE.
  - **BASE**
    - Read orbit_len bytes 0 and 1 into `len_base`, using the read rule below.
    - The core's orbit_len is cumulative and not cleared between runs, so this baseline is required.
  - **WRITE**
    - 8 cycles, i = 0..7: `core_ctrl`={1,0,0,0,i}, `core_data`=byte i of the zero-extended seed, least significant byte first.
  - **GO**
    - 1 cycle: `core_ctrl`=8'h40.
  - **SETTLE**
    - 2 cycles; `core_busy` is ignored.
  - **WAIT**
    - Exit to READ on the first cycle with `core_busy`==0.
    - If `TIMEOUT` cycles elapse first: increment `tmo_count` and go to NEXT.
    - A timed-out core is left in COMPUTE; it recovers only by system reset.
  - **READ**
    - Read orbit_len bytes 0–1, then path record bytes 0–7 (`core_ctrl`={0,0,0,1,i}).
  - **UPDATE**
    - `len` = orbit_len − `len_base`, computed mod 2^16.
    - If peak == 64'h0000_0000_baad_f00d (the core's overflow sentinel): increment `ovf_count`; results are not updated.
    - Otherwise, if `len` > `best_len` (strictly greater): load `best_seed`, `best_len`, `best_peak`.
    - Ties keep the earlier, lower seed.
  - **NEXT**
    - `cur_seed`++, `remaining`--, then go to CHECK.
    - `cur_seed` wraps modulo 2^SEED_BITS and is still processed. Seeds 0–2 reached after a wrap are skipped.
- Read rule, per byte:
  - Cycle A: drive the address on `core_ctrl` with bit 7 = 0.
  - Cycle B: hold the address; sample `core_rdata` at the end of cycle B. The core's output register lands after edge A.
  - Each byte therefore takes 2 cycles.
- `start` while `busy` is ignored. Result outputs hold their values until the next accepted `start`.
- Asynchronous reset mid-sweep: every output is 0 immediately. The core must share the same reset; the two are not resynchronised.

## Timing

- Per non-skipped, non-timeout seed: CHECK 1 + BASE 4 + WRITE 8 + GO 1 + SETTLE 2 + WAIT w + READ 20 + UPDATE 1 + NEXT 1 = 38 + w cycles. Here w ≥ 1 and equals the number of cycles spent in WAIT.
- Skipped seed: CHECK 1 + NEXT 1 = 2 cycles.
- `done` is asserted 1 cycle after the CHECK that sees `remaining`==0. `busy` falls in the same cycle as `done`.
- `seed_count`=0: `done` is asserted 2 cycles after `start`.
- `best_*` outputs update on the edge leaving UPDATE.

## Test plan

- Reset, then `start` with base=27, count=1 against the real core. Expect `done` after 38+w cycles; `best_seed`=27, `best_peak`=9232. Also expect `best_len` equal to the core's orbit_len delta, which the bench's reference model computes as steps to reach 2.
- Base=3, count=8. Expect `best_seed`=9, `best_peak`=52, `ovf_count`=0 and `tmo_count`=0. Run a second identical sweep without reset and expect an identical `best_len`, which proves the baseline subtraction.
- Base=0, count=4. Seeds 0–2 are skipped with zero core writes, checked by monitoring `core_ctrl`[7]. Expect `best_seed`=3.
- Stubbed core holding `core_busy`=1, with `TIMEOUT`=16. Expect `tmo_count`=1 and `done` asserted; `best_len` stays 0.
- Stubbed core returning peak 64'hbaadf00d. Expect `ovf_count`=1 and `best_*` unchanged. `start` pulses during the sweep are ignored.
- Assert `rst_n` low in the middle of WAIT. Every output is 0 in the same cycle; a subsequent `start` completes normally.

Source files
------------

// File: rtl/collatz_sweep.sv
// collatz_sweep: walks a contiguous seed range through the byte-wide Collatz
// core and keeps the seed with the longest orbit, its length and path record.
module collatz_sweep #(
    parameter int unsigned SEED_BITS  = 32,
    parameter int unsigned COUNT_BITS = 16,
    parameter int unsigned TIMEOUT    = 1048575
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SEED_BITS-1:0]  seed_base,
    input  logic [COUNT_BITS-1:0] seed_count,
    output logic                  busy,
    output logic                  done,
    output logic [SEED_BITS-1:0]  best_seed,
    output logic [15:0]           best_len,
    output logic [63:0]           best_peak,
    output logic [COUNT_BITS-1:0] ovf_count,
    output logic [COUNT_BITS-1:0] tmo_count,
    output logic [7:0]            core_data,
    output logic [7:0]            core_ctrl,
    input  logic [7:0]            core_rdata,
    input  logic                  core_busy
);

    localparam int unsigned TMO_BITS  = $clog2(TIMEOUT + 1);
    localparam int unsigned STEP_BITS = 5;
    localparam logic [63:0] OVF_PEAK  = 64'h0000_0000_baad_f00d;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_BASE,
        S_WRITE,
        S_GO,
        S_SETTLE,
        S_WAIT,
        S_READ,
        S_UPDATE,
        S_NEXT
    } state_t;

    state_t                  state, state_d;
    logic [STEP_BITS-1:0]    step, step_d;
    logic [TMO_BITS-1:0]     wait_cnt, wait_cnt_d;
    logic [SEED_BITS-1:0]    cur_seed, cur_seed_d;
    logic [COUNT_BITS-1:0]   remaining, remaining_d;
    logic [15:0]             len_base, len_base_d;
    logic [15:0]             rd_len, rd_len_d;
    logic [63:0]             rd_peak, rd_peak_d;
    logic                    busy_d, done_d;
    logic [SEED_BITS-1:0]    best_seed_d;
    logic [15:0]             best_len_d;
    logic [63:0]             best_peak_d;
    logic [COUNT_BITS-1:0]   ovf_count_d, tmo_count_d;
    logic [7:0]              core_data_d, core_ctrl_d;
    logic [2:0]              rd_pidx;
    logic [3:0]              ctl_byte;
    logic [15:0]             orbit_delta;
    logic [63:0]             seed_wide;

    // Path-record byte captured on the sample cycle of READ steps 4..19
    assign rd_pidx     = 3'(step[4:1] - 4'd2);
    assign orbit_delta = rd_len - len_base;
    assign seed_wide   = 64'(cur_seed);

    // Next-state, datapath updates and lookahead of the core pins for the next state
    always_comb begin
        state_d     = state;
        step_d      = step;
        wait_cnt_d  = wait_cnt;
        cur_seed_d  = cur_seed;
        remaining_d = remaining;
        len_base_d  = len_base;
        rd_len_d    = rd_len;
        rd_peak_d   = rd_peak;
        busy_d      = busy;
        done_d      = 1'b0;
        best_seed_d = best_seed;
        best_len_d  = best_len;
        best_peak_d = best_peak;
        ovf_count_d = ovf_count;
        tmo_count_d = tmo_count;
        core_data_d = 8'h00;
        core_ctrl_d = 8'h00;
        ctl_byte    = 4'd0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    cur_seed_d  = seed_base;
                    remaining_d = seed_count;
                    best_seed_d = '0;
                    best_len_d  = '0;
                    best_peak_d = '0;
                    ovf_count_d = '0;
                    tmo_count_d = '0;
                    busy_d      = 1'b1;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (remaining == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cur_seed < SEED_BITS'(3)) begin
                    state_d = S_NEXT;
                end else begin
                    step_d  = '0;
                    state_d = S_BASE;
                end
            end
            S_BASE: begin
                if (step[0]) begin
                    if (step[1]) len_base_d[15:8] = core_rdata;
                    else         len_base_d[7:0]  = core_rdata;
                end
                step_d = step + STEP_BITS'(1);
                if (step == STEP_BITS'(3)) begin
                    step_d  = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                step_d = step + STEP_BITS'(1);
                if (step == STEP_BITS'(7)) begin
                    step_d  = '0;
                    state_d = S_GO;
                end
            end
            S_GO: begin
                step_d  = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                step_d = step + STEP_BITS'(1);
                if (step == STEP_BITS'(1)) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!core_busy) begin
                    step_d  = '0;
                    state_d = S_READ;
                end else if (wait_cnt == TMO_BITS'(TIMEOUT - 1)) begin
                    tmo_count_d = tmo_count + COUNT_BITS'(1);
                    state_d     = S_NEXT;
                end else begin
                    wait_cnt_d = wait_cnt + TMO_BITS'(1);
                end
            end
            S_READ: begin
                if (step[0]) begin
                    if (step < STEP_BITS'(4)) begin
                        if (step[1]) rd_len_d[15:8] = core_rdata;
                        else         rd_len_d[7:0]  = core_rdata;
                    end else begin
                        rd_peak_d[{rd_pidx, 3'b000} +: 8] = core_rdata;
                    end
                end
                step_d = step + STEP_BITS'(1);
                if (step == STEP_BITS'(19)) begin
                    step_d  = '0;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (rd_peak == OVF_PEAK) begin
                    ovf_count_d = ovf_count + COUNT_BITS'(1);
                end else if (orbit_delta > best_len) begin
                    best_seed_d = cur_seed;
                    best_len_d  = orbit_delta;
                    best_peak_d = rd_peak;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                cur_seed_d  = cur_seed + SEED_BITS'(1);
                remaining_d = remaining - COUNT_BITS'(1);
                state_d     = S_CHECK;
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_BASE: core_ctrl_d = {7'b000_0000, step_d[1]};
            S_WRITE: begin
                core_ctrl_d = {5'b1000_0, step_d[2:0]};
                core_data_d = 8'(seed_wide >> {step_d[2:0], 3'b000});
            end
            S_GO: core_ctrl_d = 8'h40;
            S_READ: begin
                ctl_byte = step_d[4:1] - 4'd2;
                if (step_d < STEP_BITS'(4)) core_ctrl_d = {7'b000_0000, step_d[1]};
                else                        core_ctrl_d = {5'b0001_0, ctl_byte[2:0]};
            end
            default: core_ctrl_d = 8'h00;
        endcase
    end

    // State and every output/datapath register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            step      <= '0;
            wait_cnt  <= '0;
            cur_seed  <= '0;
            remaining <= '0;
            len_base  <= '0;
            rd_len    <= '0;
            rd_peak   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            best_seed <= '0;
            best_len  <= '0;
            best_peak <= '0;
            ovf_count <= '0;
            tmo_count <= '0;
            core_data <= '0;
            core_ctrl <= '0;
        end else begin
            state     <= state_d;
            step      <= step_d;
            wait_cnt  <= wait_cnt_d;
            cur_seed  <= cur_seed_d;
            remaining <= remaining_d;
            len_base  <= len_base_d;
            rd_len    <= rd_len_d;
            rd_peak   <= rd_peak_d;
            busy      <= busy_d;
            done      <= done_d;
            best_seed <= best_seed_d;
            best_len  <= best_len_d;
            best_peak <= best_peak_d;
            ovf_count <= ovf_count_d;
            tmo_count <= tmo_count_d;
            core_data <= core_data_d;
            core_ctrl <= core_ctrl_d;
        end
    end

endmodule
